// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load-store unit: byte-enable patterns and FSM states.
package load_store_unit_pkg;

   // Byte-enable patterns presented by the core (right-aligned access size).
   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Request life cycle: accept, check legality, bus access, hold result.
   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_CHECK  = 2'd1,
      LSU_ACCESS = 2'd2,
      LSU_DONE   = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, store replication/strobes,
// load lane extraction with sign or zero extension.
module lsu_align
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int BYTE_DATA_WIDTH = 4
) (
   input  logic [BYTE_DATA_WIDTH-1:0] be,
   input  logic [1:0]                 addr_lo,
   input  logic                       is_unsigned,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic [DATA_WIDTH-1:0]      rdata,
   output logic                       legal,
   output logic                       misalign,
   output logic [BYTE_DATA_WIDTH-1:0] wstrb,
   output logic [DATA_WIDTH-1:0]      wdata_rep,
   output logic [DATA_WIDTH-1:0]      rdata_ext
);

   localparam int HALF_WIDTH = DATA_WIDTH / 2;

   logic [7:0]            byte_sel;
   logic [HALF_WIDTH-1:0] half_sel;

   // Byte lane chosen by addr[1:0], half lane chosen by addr[1].
   assign byte_sel = 8'(rdata >> {addr_lo, 3'b000});
   assign half_sel = addr_lo[1] ? rdata[DATA_WIDTH-1:HALF_WIDTH] : rdata[HALF_WIDTH-1:0];

   // Decode the access size into legality, store lanes and extended load data.
   always_comb begin
      legal     = 1'b0;
      misalign  = 1'b0;
      wstrb     = be << addr_lo;
      wdata_rep = wdata;
      rdata_ext = rdata;
      case (be)
         BE_NONE: begin
            legal = 1'b0;
         end
         BE_BYTE: begin
            legal     = 1'b1;
            wdata_rep = {(DATA_WIDTH/8){wdata[7:0]}};
            rdata_ext = {{(DATA_WIDTH-8){~is_unsigned & byte_sel[7]}}, byte_sel};
         end
         BE_HALF: begin
            legal     = ~addr_lo[0];
            misalign  = addr_lo[0];
            wdata_rep = {(DATA_WIDTH/HALF_WIDTH){wdata[HALF_WIDTH-1:0]}};
            rdata_ext = {{(DATA_WIDTH-HALF_WIDTH){~is_unsigned & half_sel[HALF_WIDTH-1]}}, half_sel};
         end
         BE_WORD: begin
            legal    = (addr_lo == 2'b00);
            misalign = (addr_lo != 2'b00);
         end
         default: begin
            misalign = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load-store unit: accepts one core request, performs at most one aligned
// data-memory access and returns the extended load result.
//
// Core handshake: mem_req is raised and held by the core; mem_valid rises when
// the access is finished and stays high until mem_req is seen low, after which
// the unit returns to IDLE. Memory handshake: dmem_req is held until a single
// dmem_ack pulse; dmem_ack is only honoured while dmem_req is high.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int BYTE_DATA_WIDTH = 4,
   parameter int ADDR_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_req,
   input  logic                       mem_we,
   input  logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable,
   input  logic                       mem_unsigned,
   input  logic [ADDR_WIDTH-1:0]      mem_addr,
   input  logic [DATA_WIDTH-1:0]      mem_wdata,
   output logic                       mem_valid,
   output logic [DATA_WIDTH-1:0]      mem_rdata,
   output logic                       mem_misalign,
   output logic                       dmem_req,
   output logic                       dmem_we,
   output logic [ADDR_WIDTH-3:0]      dmem_addr,
   output logic [DATA_WIDTH-1:0]      dmem_wdata,
   output logic [BYTE_DATA_WIDTH-1:0] dmem_wstrb,
   input  logic [DATA_WIDTH-1:0]      dmem_rdata,
   input  logic                       dmem_ack,
   output lsu_state_t                 dbg_state
);

   lsu_state_t                 state_q, state_d;
   logic                       req_we_q, req_we_d;
   logic [BYTE_DATA_WIDTH-1:0] req_be_q, req_be_d;
   logic                       req_uns_q, req_uns_d;
   logic [ADDR_WIDTH-1:0]      req_addr_q, req_addr_d;
   logic [DATA_WIDTH-1:0]      req_wdata_q, req_wdata_d;
   logic                       dmem_req_q, dmem_req_d;
   logic                       dmem_we_q, dmem_we_d;
   logic [ADDR_WIDTH-3:0]      dmem_addr_q, dmem_addr_d;
   logic [DATA_WIDTH-1:0]      dmem_wdata_q, dmem_wdata_d;
   logic [BYTE_DATA_WIDTH-1:0] dmem_wstrb_q, dmem_wstrb_d;
   logic                       mem_valid_q, mem_valid_d;
   logic [DATA_WIDTH-1:0]      mem_rdata_q, mem_rdata_d;
   logic                       mem_misalign_q, mem_misalign_d;

   logic                       al_legal;
   logic                       al_misalign;
   logic [BYTE_DATA_WIDTH-1:0] al_wstrb;
   logic [DATA_WIDTH-1:0]      al_wdata;
   logic [DATA_WIDTH-1:0]      al_rdata;

   lsu_align #(
      .DATA_WIDTH      (DATA_WIDTH),
      .BYTE_DATA_WIDTH (BYTE_DATA_WIDTH)
   ) u_align (
      .be          (req_be_q),
      .addr_lo     (req_addr_q[1:0]),
      .is_unsigned (req_uns_q),
      .wdata       (req_wdata_q),
      .rdata       (dmem_rdata),
      .legal       (al_legal),
      .misalign    (al_misalign),
      .wstrb       (al_wstrb),
      .wdata_rep   (al_wdata),
      .rdata_ext   (al_rdata)
   );

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= LSU_IDLE;
         req_we_q       <= 1'b0;
         req_be_q       <= '0;
         req_uns_q      <= 1'b0;
         req_addr_q     <= '0;
         req_wdata_q    <= '0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_wdata_q   <= '0;
         dmem_wstrb_q   <= '0;
         mem_valid_q    <= 1'b0;
         mem_rdata_q    <= '0;
         mem_misalign_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_we_q       <= req_we_d;
         req_be_q       <= req_be_d;
         req_uns_q      <= req_uns_d;
         req_addr_q     <= req_addr_d;
         req_wdata_q    <= req_wdata_d;
         dmem_req_q     <= dmem_req_d;
         dmem_we_q      <= dmem_we_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_wdata_q   <= dmem_wdata_d;
         dmem_wstrb_q   <= dmem_wstrb_d;
         mem_valid_q    <= mem_valid_d;
         mem_rdata_q    <= mem_rdata_d;
         mem_misalign_q <= mem_misalign_d;
      end
   end

   // Next-state logic: request sequencing through check, access and completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE:   if (mem_req) state_d = LSU_CHECK;
         LSU_CHECK:  state_d = al_legal ? LSU_ACCESS : LSU_DONE;
         LSU_ACCESS: if (dmem_req_q && dmem_ack) state_d = LSU_DONE;
         LSU_DONE:   if (!mem_req) state_d = LSU_IDLE;
         default:    state_d = LSU_IDLE;
      endcase
   end

   // Datapath updates per state; request inputs are only captured in IDLE.
   always_comb begin
      req_we_d       = req_we_q;
      req_be_d       = req_be_q;
      req_uns_d      = req_uns_q;
      req_addr_d     = req_addr_q;
      req_wdata_d    = req_wdata_q;
      dmem_req_d     = dmem_req_q;
      dmem_we_d      = dmem_we_q;
      dmem_addr_d    = dmem_addr_q;
      dmem_wdata_d   = dmem_wdata_q;
      dmem_wstrb_d   = dmem_wstrb_q;
      mem_valid_d    = mem_valid_q;
      mem_rdata_d    = mem_rdata_q;
      mem_misalign_d = mem_misalign_q;
      case (state_q)
         LSU_IDLE: begin
            if (mem_req) begin
               req_we_d    = mem_we;
               req_be_d    = mem_byte_enable;
               req_uns_d   = mem_unsigned;
               req_addr_d  = mem_addr;
               req_wdata_d = mem_wdata;
            end
         end
         LSU_CHECK: begin
            if (al_legal) begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = req_we_q;
               dmem_addr_d  = req_addr_q[ADDR_WIDTH-1:2];
               dmem_wdata_d = req_we_q ? al_wdata : '0;
               dmem_wstrb_d = req_we_q ? al_wstrb : '0;
            end else begin
               // No-op or rejected: complete immediately with zero data.
               mem_valid_d    = 1'b1;
               mem_misalign_d = al_misalign;
               mem_rdata_d    = '0;
            end
         end
         LSU_ACCESS: begin
            if (dmem_req_q && dmem_ack) begin
               dmem_req_d     = 1'b0;
               dmem_we_d      = 1'b0;
               dmem_addr_d    = '0;
               dmem_wdata_d   = '0;
               dmem_wstrb_d   = '0;
               mem_valid_d    = 1'b1;
               mem_misalign_d = 1'b0;
               mem_rdata_d    = req_we_q ? '0 : al_rdata;
            end
         end
         LSU_DONE: begin
            if (!mem_req) begin
               mem_valid_d    = 1'b0;
               mem_misalign_d = 1'b0;
               mem_rdata_d    = '0;
            end
         end
         default: begin
            dmem_req_d = 1'b0;
         end
      endcase
   end

   assign mem_valid    = mem_valid_q;
   assign mem_rdata    = mem_rdata_q;
   assign mem_misalign = mem_misalign_q;
   assign dmem_req     = dmem_req_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign dmem_wstrb   = dmem_wstrb_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard monitor.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_byte_enable = '0;
  logic        mem_unsigned = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_misalign;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  lsu_state_t  dbg_state;

  load_store_unit dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_byte_enable (mem_byte_enable),
    .mem_unsigned    (mem_unsigned),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_valid       (mem_valid),
    .mem_rdata       (mem_rdata),
    .mem_misalign    (mem_misalign),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wstrb      (dmem_wstrb),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [66:0] exp_bus_q[$];   // {we, word addr, wdata, wstrb}
  logic [32:0] exp_resp_q[$];  // {misalign, rdata}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic        resp_en = 1'b1;
  logic        force_ack = 1'b0;
  logic        resp_ack = 1'b0;
  int          ack_delay = 0;
  logic [31:0] mem_word = '0;
  int          wait_cnt = 0;

  assign dmem_ack = resp_en ? resp_ack : force_ack;

  always @(negedge clk) begin
    if (dmem_req && !resp_ack) begin
      if (wait_cnt >= ack_delay) begin
        resp_ack   = 1'b1;
        dmem_rdata = mem_word;
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  int   req_hi_total = 0;
  int   bus_total = 0;
  logic req_prev = 1'b0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (dmem_req === 1'b1) req_hi_total++;
    if (dmem_req === 1'b1 && !req_prev) begin
      bus_total++;
      if (exp_bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected actual=%0h expected=none", {dmem_we, dmem_addr, dmem_wdata, dmem_wstrb});
      end else begin
        check("bus_fields", {dmem_we, dmem_addr, dmem_wdata, dmem_wstrb}, exp_bus_q.pop_front());
      end
    end
    if (mem_valid === 1'b1 && !valid_prev) begin
      if (exp_resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected actual=%0h expected=none", {mem_misalign, mem_rdata});
      end else begin
        check("resp_fields", {mem_misalign, mem_rdata}, exp_resp_q.pop_front());
      end
    end
    req_prev   = (dmem_req === 1'b1);
    valid_prev = (mem_valid === 1'b1);
  end

  // ---------------- driver ----------------
  task automatic do_req(input string name, input logic we, input logic [3:0] be, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word,
                        input int delay, input int hold, input logic early, input logic bus,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic exp_mis, input int exp_lat);
    int lat;
    int hi0;
    int bus0;
    if (bus) exp_bus_q.push_back({we, addr[31:2], exp_wdata, exp_wstrb});
    exp_resp_q.push_back({exp_mis, exp_rdata});
    ack_delay = delay;
    mem_word  = word;
    hi0  = req_hi_total;
    bus0 = bus_total;
    mem_we = we; mem_byte_enable = be; mem_unsigned = uns;
    mem_addr = addr; mem_wdata = wdata; mem_req = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        // Scramble request inputs once captured; they must be ignored now.
        mem_we = ~we; mem_byte_enable = ~be; mem_unsigned = ~uns;
        mem_addr = ~addr; mem_wdata = ~wdata;
        if (early) mem_req = 1'b0;
      end
      if (mem_valid === 1'b1) break;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_bus_count"}, bus_total - bus0, bus ? 1 : 0);
    if (bus) check({name, "_req_hold"}, req_hi_total - hi0, delay + 1);
    if (early) begin
      @(posedge clk); @(negedge clk);
      check({name, "_pulse_end"}, mem_valid, 1'b0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        check({name, "_held"}, {mem_valid, mem_misalign, mem_rdata}, {1'b1, exp_mis, exp_rdata});
      end
      mem_req = 1'b0;
      @(posedge clk); @(negedge clk);
      check({name, "_valid_drop"}, mem_valid, 1'b0);
    end
    mem_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check({name, "_idle"}, dbg_state, LSU_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {mem_valid, mem_rdata, mem_misalign, dmem_req, dmem_we,
                            dmem_addr, dmem_wdata, dmem_wstrb}, 128'd0);
    check("reset_state", dbg_state, LSU_IDLE);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    //      name        we  be    uns addr       wdata         word          dly hold early bus wstrb  exp_wdata     exp_rdata     mis lat
    do_req("sw",        1, 4'hF, 0, 32'h104, 32'hDEADBEEF, 32'h0,        0,  0,   0,    1,  4'hF, 32'hDEADBEEF, 32'h0,        0,  3);
    do_req("sb",        1, 4'h1, 0, 32'h103, 32'h000000A5, 32'h0,        0,  0,   0,    1,  4'h8, 32'hA5A5A5A5, 32'h0,        0,  3);
    do_req("lb",        0, 4'h1, 0, 32'h102, 32'h0,        32'h00F30000, 0,  0,   0,    1,  4'h0, 32'h0,        32'hFFFFFFF3, 0,  3);
    do_req("lbu",       0, 4'h1, 1, 32'h102, 32'h0,        32'h00F30000, 0,  0,   0,    1,  4'h0, 32'h0,        32'h000000F3, 0,  3);
    do_req("lb_lane3",  0, 4'h1, 0, 32'h107, 32'h0,        32'h80000000, 0,  0,   0,    1,  4'h0, 32'h0,        32'hFFFFFF80, 0,  3);
    do_req("lh_mis",    0, 4'h3, 0, 32'h101, 32'h0,        32'h00F30000, 0,  0,   0,    0,  4'h0, 32'h0,        32'h0,        1,  2);
    do_req("lw_slow",   0, 4'hF, 0, 32'h208, 32'h0,        32'h12345678, 5,  3,   0,    1,  4'h0, 32'h0,        32'h12345678, 0,  8);
    do_req("lh_hi",     0, 4'h3, 0, 32'h106, 32'h0,        32'h80017FFF, 1,  0,   0,    1,  4'h0, 32'h0,        32'hFFFF8001, 0,  4);
    do_req("lhu_lo",    0, 4'h3, 1, 32'h104, 32'h0,        32'h80017FFF, 0,  1,   0,    1,  4'h0, 32'h0,        32'h00007FFF, 0,  3);
    do_req("sh_early",  1, 4'h3, 0, 32'h10E, 32'hFFFFBEEF, 32'h0,        2,  0,   1,    1,  4'hC, 32'hBEEFBEEF, 32'h0,        0,  5);
    do_req("noop",      1, 4'h0, 0, 32'h100, 32'h11111111, 32'h0,        0,  1,   0,    0,  4'h0, 32'h0,        32'h0,        0,  2);
    do_req("be_bad",    0, 4'h5, 0, 32'h100, 32'h0,        32'h55555555, 0,  0,   0,    0,  4'h0, 32'h0,        32'h0,        1,  2);
    do_req("sw_mis",    1, 4'hF, 0, 32'h102, 32'h12345678, 32'h0,        0,  0,   0,    0,  4'h0, 32'h0,        32'h0,        1,  2);

    // Reset while the bus access is outstanding, then a stray ack.
    ack_delay = 100;
    exp_bus_q.push_back({1'b0, 30'h000000C0, 32'h0, 4'h0});
    mem_we = 1'b0; mem_byte_enable = 4'hF; mem_unsigned = 1'b0;
    mem_addr = 32'h300; mem_wdata = 32'h0; mem_req = 1'b1;
    n = 0;
    while (n < 20 && dmem_req !== 1'b1) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    check("rst_reached_access", dbg_state, LSU_ACCESS);
    rst = 1'b1;
    mem_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_outputs", {mem_valid, mem_rdata, mem_misalign, dmem_req, dmem_we,
                          dmem_addr, dmem_wdata, dmem_wstrb}, 128'd0);
    check("rst_state", dbg_state, LSU_IDLE);
    resp_en = 1'b0;
    force_ack = 1'b1;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    force_ack = 1'b0;
    check("late_ack_ignored", {dbg_state, dmem_req, mem_valid}, {LSU_IDLE, 1'b0, 1'b0});
    resp_en = 1'b1;
    @(posedge clk); @(negedge clk);

    do_req("sw_after_rst", 1, 4'hF, 0, 32'h20, 32'h0BADF00D, 32'h0, 0, 0, 0, 1, 4'hF, 32'h0BADF00D, 32'h0, 0, 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bus_queue_drained", exp_bus_q.size(), 0);
    check("resp_queue_drained", exp_resp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load-store unit: the responder on the decode unit's `mem_req`/`mem_valid` handshake. It takes the ALU-computed address, store data and byte-enable pattern from the core, performs one aligned access on the data-memory bus, and returns sign- or zero-extended load data for register-file write-back. It sits between the decode/ALU datapath and the data memory.

## Interface
- `DATA_WIDTH`, 32: data path width.
- `BYTE_DATA_WIDTH`, 4: byte lanes per word.
- `ADDR_WIDTH`, 32: byte-address width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `mem_req`  in  1: core request, level-held until `mem_valid` is seen.
- `mem_we`  in  1: 1 = store, 0 = load.
- `mem_byte_enable`  in  BYTE_DATA_WIDTH: 0001 byte, 0011 half, 1111 word, 0000 no-op.
- `mem_unsigned`  in  1: zero-extend loads (funct3[2]).
- `mem_addr`  in  ADDR_WIDTH: byte address (ALU result).
- `mem_wdata`  in  DATA_WIDTH: store data (rs2), right-aligned.
- `mem_valid`  out  1: access complete; held until `mem_req` falls.
- `mem_rdata`  out  DATA_WIDTH: extended load data, stable while `mem_valid`=1.
- `mem_misalign`  out  1: request rejected; valid while `mem_valid`=1.
- `dmem_req`  out  1: memory bus request.
- `dmem_we`  out  1: memory write.
- `dmem_addr`  out  ADDR_WIDTH-2: word address.
- `dmem_wdata`  out  DATA_WIDTH: lane-replicated store data.
- `dmem_wstrb`  out  BYTE_DATA_WIDTH: lane write strobes.
- `dmem_rdata`  in  DATA_WIDTH: read word, valid in the `dmem_ack` cycle.
- `dmem_ack`  in  1: one-cycle completion pulse. It is sampled only while `dmem_req`=1.

## Operation
- FSM states:
  - IDLE: `mem_req`=1 latches all request inputs and goes to CHECK.
  - CHECK: a legal access goes to ACCESS. A no-op or rejected request goes to DONE.
  - ACCESS: `dmem_req` is held until `dmem_ack`, then goes to DONE.
  - DONE: `mem_valid`=1 until `mem_req`=0 is sampled, then returns to IDLE.
- Legality:
  - byte: always legal.
  - half: `addr[0]`=0.
  - word: `addr[1:0]`=0.
  - Any other pattern, or a misaligned address, sets `mem_misalign`=1, issues no bus access, and returns `mem_rdata`=0.
- 0000 is a no-op: no bus access, `mem_misalign`=0, `mem_rdata`=0.
- Store:
  - `dmem_wstrb` = `be << addr[1:0]`.
  - `dmem_wdata` = byte replicated ×4, half replicated ×2, or the word.
  - `mem_rdata`=0.
- Load:
  - `dmem_wstrb`=0.
  - Select the byte at lane `addr[1:0]` or the half at `addr[1]`.
  - Sign-extend unless `mem_unsigned`, in which case zero-extend.
- `dmem_addr` = `addr[ADDR_WIDTH-1:2]`.
- All outputs are registered.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-access: `dmem_req` drops the next cycle. A late `dmem_ack` is ignored.
- Cycle timeline (request sampled in IDLE at cycle N):
  - N+1: CHECK.
  - N+2: `dmem_req`=1.
  - Ack at cycle M: `dmem_req`=0 and `mem_valid`=1 at M+1.
  - Zero-wait memory (ack at N+2) gives `mem_valid` at N+3.
- No-op or rejected request: `mem_valid`=1 at N+2.
- After `mem_req`=0 is sampled in DONE, `mem_valid`=0 the next cycle. A new request is accepted no earlier than one cycle after that (IDLE).
- If `mem_req` falls during CHECK or ACCESS, the access still completes and `mem_valid` pulses for exactly one cycle.
- Request inputs are ignored outside IDLE.

## Structure
- Shared package holds:
  - byte-enable encodings (`BE_NONE`, `BE_BYTE`, `BE_HALF`, `BE_WORD`);
  - the FSM state encoding (`LSU_IDLE`, `LSU_CHECK`, `LSU_ACCESS`, `LSU_DONE`).
- Sub-module `lsu_align` (purely combinational) holds the legality check, store lane replication/strobe generation, and load lane extraction/extension.
- The top level holds the FSM and registers.

## Test plan
- SW addr 0x104, data 0xDEADBEEF, ack at cycle N+2 → `dmem_addr`=0x41, `dmem_wstrb`=1111, `dmem_wdata`=0xDEADBEEF, `mem_valid` at N+3.
- SB addr 0x103, data 0x000000A5 → `dmem_wstrb`=1000, `dmem_wdata`=0xA5A5A5A5.
- LB addr 0x102 with `dmem_rdata`=0x00F30000 → signed `mem_rdata`=0xFFFFFFF3; `mem_unsigned`=1 → 0x000000F3.
- LH addr 0x101 → `mem_misalign`=1, no `dmem_req`, `mem_rdata`=0, `mem_valid` at N+2.
- Load with ack delayed 5 cycles, `mem_req` held 3 cycles past `mem_valid` → `dmem_req` held until ack, `mem_valid` held while `mem_req`=1 and cleared one cycle after `mem_req` falls.
- `rst` asserted while in ACCESS, then ack the following cycle → all outputs 0, state IDLE, ack ignored, and the next request is served normally.
